fulladd_r: RTL and testbench

//   Ripple-carry adder, WIDTH bits wide (4 by default), with a registered result.

---
 rtl/fulladd_r_pkg.sv | 14 +
 rtl/full_adder.sv | 17 +
 rtl/fulladd_r.sv | 48 ++++
 tb/tb_fulladd_r.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fulladd_r_pkg.sv
// Bit-level full-adder equations shared by the ripple-carry adder slice.
// Only pure functions live here; the adder width stays local to each instance.
package fulladd_r_pkg;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    // Generate when both bits are set, propagate the incoming carry when exactly one is.
    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit purely combinational full adder; one stage of the ripple chain.
module full_adder
    import fulladd_r_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = fa_sum(a, b, ci);
        co = fa_carry(a, b, ci);
    end

endmodule

// File: rtl/fulladd_r.sv
// WIDTH-bit ripple-carry adder with registered sum and carry-out (latency 1).
// The carry chain is built from full_adder stages, LSB to MSB.
module fulladd_r #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             cin,
    output logic [WIDTH-1:0] o,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign carry[0] = cin;

    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        full_adder u_fa (
            .a  (i0[k]),
            .b  (i1[k]),
            .ci (carry[k]),
            .s  (sum_d[k]),
            .co (carry[k+1])
        );
    end

    assign cout_d = carry[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign o    = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_fulladd_r.sv
// Scoreboard bench for fulladd_r: the driver queues expected {cout,o} per applied vector,
// a monitor pops and compares one edge later.
module tb_fulladd_r;

    logic       clk;
    logic       reset;
    logic [3:0] i0;
    logic [3:0] i1;
    logic       cin;
    logic [3:0] o;
    logic       cout;

    typedef struct {
        logic [4:0] exp;
        string      tag;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_cmp;
    int       n_fail;

    fulladd_r #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .i0    (i0),
        .i1    (i1),
        .cin   (cin),
        .o     (o),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {cout,o}=%b required %b", name, act, exp);
        end
    endtask

    // Drive one vector between edges and queue the result expected after the next rise.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [4:0] exp, input string tag);
        sb_item_t it;
        @(negedge clk);
        i0  = a;
        i1  = b;
        cin = c;
        it.exp = exp;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    // Monitor: compare after every rising edge for which an expectation is pending.
    always @(posedge clk) begin
        sb_item_t it;
        #1;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, {cout, o}, it.exp);
        end
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        i0     = 4'b1111;
        i1     = 4'b1111;
        cin    = 1'b1;

        // 1. Held in reset with maximal inputs: outputs stay zero across edges.
        #1;
        check("reset_async", {cout, o}, 5'b0_0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {cout, o}, 5'b0_0000);
        end

        // Release reset at a falling edge; the next rise captures 1111+1111+1.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_release_before_edge", {cout, o}, 5'b0_0000);
        sb_q.push_back('{exp: 5'b1_1111, tag: "first_capture"});

        // 2. Basic sums.
        apply(4'b0110, 4'b0111, 1'b1, 5'b0_1110, "add_0110_0111_1");
        apply(4'b0011, 4'b1001, 1'b1, 5'b0_1101, "add_0011_1001_1");
        apply(4'b0000, 4'b0111, 1'b0, 5'b0_0111, "add_0000_0111_0");

        // 3. Full ripple, wrap-around and maximum case.
        apply(4'b1111, 4'b0001, 1'b1, 5'b1_0001, "ripple_1111_0001_1");
        apply(4'b1111, 4'b0000, 1'b1, 5'b1_0000, "wrap_1111_0000_1");
        apply(4'b1111, 4'b1111, 1'b1, 5'b1_1111, "max_1111_1111_1");

        // 4. Latency: inputs change after the edge, outputs must hold the sampled sum.
        apply(4'b0101, 4'b0010, 1'b0, 5'b0_0111, "latency_sample");
        @(posedge clk);
        #2;
        i0  = 4'b1000;
        i1  = 4'b1000;
        cin = 1'b1;
        #1;
        check("latency_hold_after_change", {cout, o}, 5'b0_0111);
        #1;
        check("latency_hold_before_edge", {cout, o}, 5'b0_0111);
        apply(4'b1000, 4'b1000, 1'b1, 5'b1_0001, "latency_next");

        // 5. Asynchronous reset mid-cycle while o=1110.
        apply(4'b0110, 4'b0111, 1'b1, 5'b0_1110, "pre_reset_1110");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_midcycle", {cout, o}, 5'b0_0000);
        @(negedge clk);
        reset = 1'b1;

        // 6. Exhaustive 512 combinations against an arithmetic reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [4:0] ref_sum;
                    ref_sum = 5'(a) + 5'(b) + 5'(c);
                    apply(4'(a), 4'(b), 1'(c), ref_sum, "exhaustive");
                end
            end
        end

        // Drain the scoreboard within a bounded number of edges.
        for (int k = 0; k < 4 && sb_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
